// File: rtl/riscv_mem_pkg.sv
// Shared constants for the RISC-V memory responder:
// IO select bit, IO register offsets and TXSTAT bit positions.
package riscv_mem_pkg;

    localparam int IO_BIT = 31;

    typedef enum logic [1:0] {
        OFF_LED    = 2'd0,
        OFF_TXDATA = 2'd1,
        OFF_TXSTAT = 2'd2,
        OFF_CYCLE  = 2'd3
    } io_off_e;

    localparam int ST_FULL      = 0;
    localparam int ST_EMPTY     = 1;
    localparam int ST_OVF       = 2;
    localparam int ST_COUNT_LSB = 3;

endpackage

// File: rtl/riscv_mem_responder_tx_fifo.sv
// Console TX byte FIFO: push side from the bus, pop side on valid/ready.
// A push into a full FIFO is dropped unless a pop frees a slot that cycle.
module tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       push_data_i,
    output logic                   full_o,
    output logic                   drop_o,
    input  logic                   pop_i,
    output logic                   valid_o,
    output logic [WIDTH-1:0]       data_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_q, rd_d, wr_q, wr_d;
    logic [PW:0]      cnt_q, cnt_d;
    logic             pop_ok, push_ok;

    assign valid_o = (cnt_q != '0);
    assign full_o  = (cnt_q == CNT_FULL);
    assign data_o  = mem_q[rd_q];
    assign count_o = cnt_q;

    // Accept/drop decision and next pointer/count values
    always_comb begin
        pop_ok  = pop_i && valid_o;
        push_ok = push_i && (!full_o || pop_ok);
        drop_o  = push_i && !push_ok;
        rd_d    = rd_q + PW'(pop_ok);
        wr_d    = wr_q + PW'(push_ok);
        cnt_d   = cnt_q + (PW+1)'(push_ok) - (PW+1)'(pop_ok);
    end

    // Pointer, count and storage registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
            if (push_ok) mem_q[wr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/riscv_mem_responder.sv
// Bus responder: word RAM with registered read, LED, console TX FIFO.
// Define CYCLE_COUNTER_EN to add a readable free-running cycle counter.
module riscv_mem_responder
    import riscv_mem_pkg::*;
#(
    parameter int RAM_WORDS = 1024,
    parameter int TX_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    output logic [31:0] ReadData,
    output logic [7:0]  leds,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int AW = $clog2(RAM_WORDS);
    localparam int CW = $clog2(TX_DEPTH) + 1;

    logic [31:0]   ram_q [RAM_WORDS];
    logic [AW-1:0] ram_idx;
    logic          is_io;
    io_off_e       off;
    logic [7:0]    led_q;
    logic          ovf_q;
    logic [31:0]   rdata_q, rdata_d, io_rd, stat, cyc_val;
    logic          wr_led, wr_tx, wr_stat;
    logic          fifo_full, fifo_drop;
    logic [CW-1:0] fifo_cnt;
    logic          unused_addr;

    assign is_io   = Address[IO_BIT];
    assign off     = io_off_e'(Address[3:2]);
    assign ram_idx = Address[AW+1:2];
    assign wr_led  = MemWrite && is_io && (off == OFF_LED);
    assign wr_tx   = MemWrite && is_io && (off == OFF_TXDATA);
    assign wr_stat = MemWrite && is_io && (off == OFF_TXSTAT);

    assign unused_addr = ^{Address[30:AW+2], Address[1:0]};

    assign ReadData = rdata_q;
    assign leds     = led_q;

    tx_fifo #(
        .DEPTH (TX_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .push_i      (wr_tx),
        .push_data_i (WriteData[7:0]),
        .full_o      (fifo_full),
        .drop_o      (fifo_drop),
        .pop_i       (tx_ready),
        .valid_o     (tx_valid),
        .data_o      (tx_data),
        .count_o     (fifo_cnt)
    );

`ifdef CYCLE_COUNTER_EN
    logic [31:0] cyc_q;

    // Free-running cycle counter, wraps at 2^32
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc_q <= '0;
        else          cyc_q <= cyc_q + 32'd1;
    end

    assign cyc_val = cyc_q;
`else
    assign cyc_val = '0;
`endif

    // TXSTAT word built from current (pre-write) FIFO state
    always_comb begin
        stat                        = '0;
        stat[ST_FULL]               = fifo_full;
        stat[ST_EMPTY]              = !tx_valid;
        stat[ST_OVF]                = ovf_q;
        stat[ST_COUNT_LSB +: CW]    = fifo_cnt;
    end

    // Read mux: RAM is read-first, IO sampled before this cycle's write
    always_comb begin
        io_rd = '0;
        unique case (off)
            OFF_LED:    io_rd = {24'b0, led_q};
            OFF_TXDATA: io_rd = '0;
            OFF_TXSTAT: io_rd = stat;
            OFF_CYCLE:  io_rd = cyc_val;
        endcase
        rdata_d = is_io ? io_rd : ram_q[ram_idx];
    end

    // Word RAM write port, contents survive reset
    always_ff @(posedge clk) begin
        if (MemWrite && !is_io) ram_q[ram_idx] <= WriteData;
    end

    // Read data, LED register and sticky overflow flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata_q <= '0;
            led_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            rdata_q <= rdata_d;
            if (wr_led)         led_q <= WriteData[7:0];
            if (wr_stat)        ovf_q <= 1'b0;
            else if (fifo_drop) ovf_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_riscv_mem_responder.sv
// Self-checking bench for riscv_mem_responder: directed plan plus
// randomized bus traffic checked against a queue/array reference model.
module tb_riscv_mem_responder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic [31:0] ReadData;
    logic [7:0]  leds;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    int vectors = 0;
    int miscompares = 0;

    riscv_mem_responder dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .Address   (Address),
        .WriteData (WriteData),
        .MemWrite  (MemWrite),
        .ReadData  (ReadData),
        .leds      (leds),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] mm [1024];
    bit          mk [1024];
    logic [7:0]  mq [$];
    logic [7:0]  m_leds = 0;
    bit          m_ovf = 0;
    logic [31:0] m_cyc = 0;
    logic [31:0] exp_rd = 0;
    bit          exp_known = 1;
    bit          m_pop;
    int          m_idx;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_leds = 0;
            mq.delete();
            m_ovf = 0;
            m_cyc = 0;
            exp_rd = 0;
            exp_known = 1;
        end else begin
            m_idx = int'(Address[11:2]);
            m_pop = (mq.size() != 0) && tx_ready;
            exp_known = 1;
            if (!Address[31]) begin
                exp_known = mk[m_idx];
                exp_rd = mm[m_idx];
            end else begin
                case (Address[3:2])
                    2'd0: exp_rd = {24'b0, m_leds};
                    2'd1: exp_rd = 0;
                    2'd2: exp_rd = (32'(mq.size()) << 3)
                                 | (32'(m_ovf) << 2)
                                 | (32'(mq.size() == 0) << 1)
                                 | 32'(mq.size() == 4);
`ifdef CYCLE_COUNTER_EN
                    default: exp_rd = m_cyc;
`else
                    default: exp_rd = 0;
`endif
                endcase
            end
            m_cyc = m_cyc + 1;
            if (m_pop) void'(mq.pop_front());
            if (MemWrite) begin
                if (!Address[31]) begin
                    mm[m_idx] = WriteData;
                    mk[m_idx] = 1;
                end else begin
                    case (Address[3:2])
                        2'd0: m_leds = WriteData[7:0];
                        2'd1: if (mq.size() < 4) mq.push_back(WriteData[7:0]);
                              else m_ovf = 1;
                        2'd2: m_ovf = 0;
                        default: ;
                    endcase
                end
            end
        end
    end

    // ---------------- compare process ----------------
    bit started = 0;

    always @(negedge clk) begin
        if (started && reset_n) begin
            if (exp_known) chk("rdata", ReadData, exp_rd);
            chk("leds", {24'b0, leds}, {24'b0, m_leds});
            chk("tx_valid", {31'b0, tx_valid}, {31'b0, mq.size() != 0});
            if (mq.size() != 0) chk("tx_data", {24'b0, tx_data}, {24'b0, mq[0]});
        end
    end

    // ---------------- stimulus ----------------
    task automatic bus(input logic [31:0] a, input logic [31:0] d,
                       input logic w);
        Address = a;
        WriteData = d;
        MemWrite = w;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] v1, v2, ra;

    initial begin
        reset_n = 1'b0;
        Address = 0;
        WriteData = 0;
        MemWrite = 0;
        tx_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rdata", ReadData, 32'h0);
        chk("reset_leds", {24'b0, leds}, 32'h0);
        chk("reset_txvalid", {31'b0, tx_valid}, 32'h0);
        reset_n = 1'b1;
        started = 1;
        bus(32'h0, 0, 0);

        // RAM write/read and alias
        bus(32'h0000_0010, 32'hDEAD_BEEF, 1);
        bus(32'h0000_0010, 0, 0);
        chk("ram_read", ReadData, 32'hDEAD_BEEF);
        bus(32'h0000_1010, 0, 0);
        chk("ram_alias", ReadData, 32'hDEAD_BEEF);

        // LED
        bus(32'h8000_0000, 32'h0000_01A5, 1);
        chk("led_out", {24'b0, leds}, 32'hA5);
        bus(32'h8000_0000, 0, 0);
        chk("led_read", ReadData, 32'h0000_00A5);

        // FIFO overflow
        tx_ready = 0;
        for (int i = 0; i < 5; i++) bus(32'h8000_0004, 32'h41 + i, 1);
        bus(32'h8000_0008, 0, 0);
        chk("txstat_full_ovf", ReadData, 32'h0000_0025);
        tx_ready = 1;
        for (int i = 0; i < 4; i++) begin
            chk("tx_order", {24'b0, tx_data}, 32'h41 + i);
            bus(32'h0, 0, 0);
        end
        chk("tx_drained", {31'b0, tx_valid}, 32'h0);
        bus(32'h8000_0008, 0, 1);
        bus(32'h8000_0008, 0, 0);
        chk("ovf_clear", ReadData, 32'h0000_0002);

        // Full FIFO, simultaneous push and pop
        tx_ready = 0;
        for (int i = 1; i <= 4; i++) bus(32'h8000_0004, i, 1);
        tx_ready = 1;
        bus(32'h8000_0004, 32'h55, 1);
        tx_ready = 0;
        bus(32'h8000_0008, 0, 0);
        chk("push_pop_full", ReadData, 32'h0000_0021);
        tx_ready = 1;
        for (int i = 0; i < 4; i++) begin
            chk("pp_order", {24'b0, tx_data}, (i == 3) ? 32'h55 : 32'(i + 2));
            bus(32'h0, 0, 0);
        end
        chk("pp_drained", {31'b0, tx_valid}, 32'h0);

        // Read-during-write
        bus(32'h20, 32'h1111_1111, 1);
        bus(32'h20, 32'h2222_2222, 1);
        chk("rdw_old", ReadData, 32'h1111_1111);
        bus(32'h20, 0, 0);
        chk("rdw_new", ReadData, 32'h2222_2222);

        // Cycle counter, address cycles 8 apart
        bus(32'h8000_000C, 0, 0);
        v1 = ReadData;
        repeat (7) bus(32'h0, 0, 0);
        bus(32'h8000_000C, 0, 0);
        v2 = ReadData;
`ifdef CYCLE_COUNTER_EN
        chk("cycle_delta", v2 - v1, 32'd8);
`else
        chk("cycle_zero1", v1, 32'h0);
        chk("cycle_zero2", v2, 32'h0);
`endif

        // Asynchronous reset mid-operation
        tx_ready = 0;
        bus(32'h8000_0000, 32'h3C, 1);
        bus(32'h8000_0004, 32'h77, 1);
        bus(32'h0, 0, 0);
        reset_n = 1'b0;
        #2;
        chk("async_leds", {24'b0, leds}, 32'h0);
        chk("async_txvalid", {31'b0, tx_valid}, 32'h0);
        chk("async_rdata", ReadData, 32'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        bus(32'h0000_0010, 0, 0);
        chk("ram_kept", ReadData, 32'hDEAD_BEEF);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            tx_ready = ($urandom_range(0, 3) != 0);
            ra = $urandom;
            if ($urandom_range(0, 1) == 0) begin
                ra[31] = 1'b0;
                ra[11:6] = 6'b0;
            end else begin
                ra[31] = 1'b1;
            end
            bus(ra, $urandom, $urandom_range(0, 1) == 1);
        end

        bus(32'h0, 0, 0);
        started = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
